// File: rtl/spi_master_sequencer.sv
// SPI mode-0 master: sequences one clock_divider through config, CS setup, N byte bursts, CS hold.
// Latency: busy 1 cycle after start, CS low 2 cycles after start, then setup + per-byte bursts + hold.
// Backpressure: stalls in LOAD (CS low, SCLK idle) until a tx byte is valid; rx has no backpressure.
module spi_master_sequencer #(
  parameter int P_CS_SETUP = 2,
  parameter int P_CS_HOLD  = 2,
  parameter int P_GAP      = 0
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_start,
  input  logic [7:0] i_len,
  input  logic [7:0] i_cdiv,
  output logic       o_busy,
  output logic       o_done,
  input  logic [7:0] i_tx_data,
  input  logic       i_tx_valid,
  output logic       o_tx_ready,
  output logic [7:0] o_rx_data,
  output logic       o_rx_valid,
  output logic       o_sclk,
  output logic       o_mosi,
  input  logic       i_miso,
  output logic       o_cs_n,
  output logic [8:0] o_div_config,
  output logic       o_div_start_n,
  input  logic       i_div_ready,
  input  logic       i_div_clk,
  input  logic       i_div_rising,
  input  logic       i_div_falling
);

  typedef enum logic [3:0] {
    S_IDLE, S_CONFIG, S_CS_SETUP, S_LOAD, S_START,
    S_WAIT_BUSY, S_WAIT_DONE, S_GAP, S_CS_HOLD, S_DONE
  } state_t;

  state_t     r_state;
  logic [7:0] r_len;
  logic [7:0] r_div;
  logic [7:0] r_cnt;
  logic [7:0] r_tx_sh;
  logic [7:0] r_rx_sh;
  logic [2:0] r_bitcnt;

  logic [7:0] w_cdiv_even;
  logic [7:0] w_cdiv_san;

  // Divider only supports even divisors of at least 2
  assign w_cdiv_even = {i_cdiv[7:1], 1'b0};
  assign w_cdiv_san  = (w_cdiv_even < 8'd2) ? 8'd2 : w_cdiv_even;

  // SCLK is the divider clock itself; it idles low between bursts
  assign o_sclk = i_div_clk;

  // Transaction sequencer: state, counters, shift registers and all registered outputs
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state       <= S_IDLE;
      r_len         <= 8'd0;
      r_div         <= 8'd0;
      r_cnt         <= 8'd0;
      r_tx_sh       <= 8'd0;
      r_rx_sh       <= 8'd0;
      r_bitcnt      <= 3'd0;
      o_busy        <= 1'b0;
      o_done        <= 1'b0;
      o_tx_ready    <= 1'b0;
      o_rx_data     <= 8'd0;
      o_rx_valid    <= 1'b0;
      o_mosi        <= 1'b0;
      o_cs_n        <= 1'b1;
      o_div_config  <= 9'd0;
      o_div_start_n <= 1'b1;
    end else begin
      o_done     <= 1'b0;
      o_rx_valid <= 1'b0;

      // Edge strobes can arrive as soon as the divider drops ready, so both wait states shift
      if (r_state == S_WAIT_BUSY || r_state == S_WAIT_DONE) begin
        if (i_div_rising) begin
          r_rx_sh <= {r_rx_sh[6:0], i_miso};
        end
        // The 8th falling edge ends the byte; MOSI keeps its last bit
        if (i_div_falling && (r_bitcnt != 3'd7)) begin
          r_tx_sh  <= {r_tx_sh[6:0], 1'b0};
          o_mosi   <= r_tx_sh[6];
          r_bitcnt <= r_bitcnt + 3'd1;
        end
      end

      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            if (i_len == 8'd0) begin
              o_done  <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_len   <= i_len;
              r_div   <= w_cdiv_san;
              o_busy  <= 1'b1;
              if (i_div_ready) begin
                o_div_config <= {w_cdiv_san, 1'b1};
              end
              r_state <= S_CONFIG;
            end
          end
        end

        S_CONFIG: begin
          // Load strobe is held for exactly one cycle, then CS drops
          if (o_div_config[0]) begin
            o_div_config[0] <= 1'b0;
            o_cs_n          <= 1'b0;
            r_cnt           <= 8'd0;
            r_state         <= S_CS_SETUP;
          end else if (i_div_ready) begin
            o_div_config <= {r_div, 1'b1};
          end
        end

        S_CS_SETUP: begin
          if (r_cnt == 8'(P_CS_SETUP - 1)) begin
            o_tx_ready <= 1'b1;
            r_state    <= S_LOAD;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end

        S_LOAD: begin
          if (i_tx_valid && o_tx_ready) begin
            o_tx_ready    <= 1'b0;
            r_tx_sh       <= i_tx_data;
            o_mosi        <= i_tx_data[7];
            r_rx_sh       <= 8'd0;
            r_bitcnt      <= 3'd0;
            o_div_start_n <= 1'b0;
            r_state       <= S_START;
          end
        end

        S_START: begin
          o_div_start_n <= 1'b1;
          r_state       <= S_WAIT_BUSY;
        end

        S_WAIT_BUSY: begin
          if (!i_div_ready) begin
            r_state <= S_WAIT_DONE;
          end
        end

        S_WAIT_DONE: begin
          if (i_div_ready) begin
            o_rx_data  <= r_rx_sh;
            o_rx_valid <= 1'b1;
            r_len      <= r_len - 8'd1;
            r_cnt      <= 8'd0;
            if (r_len == 8'd1) begin
              r_state <= S_CS_HOLD;
            end else if (P_GAP == 0) begin
              o_tx_ready <= 1'b1;
              r_state    <= S_LOAD;
            end else begin
              r_state <= S_GAP;
            end
          end
        end

        S_GAP: begin
          if (r_cnt == 8'(P_GAP - 1)) begin
            o_tx_ready <= 1'b1;
            r_state    <= S_LOAD;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end

        S_CS_HOLD: begin
          if (r_cnt == 8'(P_CS_HOLD - 1)) begin
            o_cs_n  <= 1'b1;
            o_done  <= 1'b1;
            o_busy  <= 1'b0;
            r_state <= S_DONE;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end

        S_DONE: begin
          r_state <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master_sequencer.sv
// Directed bench for spi_master_sequencer with a behavioural divider and SPI slave.
// Latency: checks exact cycle positions of busy, config strobe, CS and done.
// Backpressure: exercises a 20-cycle tx underflow between bytes.
module tb_spi_master_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       i_start = 1'b0;
  logic [7:0] i_len = 8'd0;
  logic [7:0] i_cdiv = 8'd0;
  logic       o_busy, o_done, o_tx_ready, o_rx_valid, o_sclk, o_mosi, o_cs_n, o_div_start_n;
  logic [7:0] o_rx_data;
  logic [8:0] o_div_config;
  logic [7:0] tx_data = 8'd0;
  logic       tx_valid = 1'b0;
  logic       miso;
  logic       div_ready, div_clk, div_rising, div_falling;

  always #5 clk = ~clk;

  spi_master_sequencer #(.P_CS_SETUP(2), .P_CS_HOLD(2), .P_GAP(0)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(i_start), .i_len(i_len), .i_cdiv(i_cdiv),
    .o_busy(o_busy), .o_done(o_done), .i_tx_data(tx_data), .i_tx_valid(tx_valid),
    .o_tx_ready(o_tx_ready), .o_rx_data(o_rx_data), .o_rx_valid(o_rx_valid),
    .o_sclk(o_sclk), .o_mosi(o_mosi), .i_miso(miso), .o_cs_n(o_cs_n),
    .o_div_config(o_div_config), .o_div_start_n(o_div_start_n),
    .i_div_ready(div_ready), .i_div_clk(div_clk),
    .i_div_rising(div_rising), .i_div_falling(div_falling)
  );

  // Behavioural clock_divider: burst of 8 slow clocks, half period = divisor/2
  logic [7:0] m_div;
  logic [7:0] m_ph;
  logic [4:0] m_edges;
  logic       m_ready, m_clk, m_active;
  logic [7:0] m_half;
  assign m_half      = m_div >> 1;
  assign div_ready   = m_ready;
  assign div_clk     = m_clk;
  assign div_rising  = m_active && (m_ph == m_half - 8'd1) && !m_clk;
  assign div_falling = m_active && (m_ph == m_half - 8'd1) && m_clk;

  initial begin
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        m_div <= 8'd2; m_ph <= 8'd0; m_edges <= 5'd0;
        m_ready <= 1'b1; m_clk <= 1'b0; m_active <= 1'b0;
      end else begin
        if (o_div_config[0]) m_div <= o_div_config[8:1];
        if (m_active) begin
          if (m_ph == m_half - 8'd1) begin
            m_clk   <= ~m_clk;
            m_ph    <= 8'd0;
            m_edges <= m_edges + 5'd1;
            if (m_edges == 5'd15) begin
              m_active <= 1'b0;
              m_ready  <= 1'b1;
            end
          end else begin
            m_ph <= m_ph + 8'd1;
          end
        end else if (m_ready && !o_div_start_n) begin
          m_ready <= 1'b0; m_active <= 1'b1; m_ph <= 8'd0; m_edges <= 5'd0;
        end
      end
    end
  end

  // Stimulus tables written by the main sequence, consumed by the feeder/slave/monitor
  logic [7:0] tx_tbl [4];
  logic [7:0] sl_tbl [4];
  int         tx_n = 0, tx_gen = 0, stall_idx = 99, stall_init = 0;
  logic       loop = 1'b1;
  logic [7:0] sl_sh = 8'd0;
  assign miso = loop ? o_mosi : sl_sh[7];

  // Monitor state
  int         cyc = 0, seen_gen = 0, tx_idx = 0, sl_idx = 0, stall_left = 0, stall_bad = 0;
  logic       hs_next = 1'b0, prev_sclk = 1'b0, prev_cs = 1'b1, rise_ok = 1'b0;
  int         rise_cnt = 0, last_rise = 0, exp_period = 4, period_bad = 0;
  int         done_cnt = 0, cs_low = 0, cs_rise = 0, rx_n = 0;
  logic [7:0] rx_log [64];

  // Feeder, slave and monitor, sampled 1 time unit after each active edge
  initial begin
    forever begin
      @(posedge clk); #1;
      cyc++;
      if (tx_gen != seen_gen) begin
        seen_gen = tx_gen; tx_idx = 0; sl_idx = 0; hs_next = 1'b0; stall_left = stall_init;
      end else if (hs_next) begin
        tx_idx++;
      end
      tx_valid = (tx_idx < tx_n);
      tx_data  = (tx_idx < 4) ? tx_tbl[tx_idx] : 8'h00;
      if (tx_idx == stall_idx && stall_left > 0) begin
        tx_valid = 1'b0;
        if (o_tx_ready) begin
          stall_left--;
          if (o_sclk || o_cs_n) stall_bad++;
        end
      end
      hs_next = o_tx_ready && tx_valid;

      if (!o_div_start_n) begin
        sl_sh = sl_tbl[sl_idx % 4]; sl_idx++;
      end else if (prev_sclk && !o_sclk) begin
        sl_sh = {sl_sh[6:0], 1'b0};
      end

      if (!o_div_start_n) rise_ok = 1'b0;
      if (o_sclk && !prev_sclk) begin
        rise_cnt++;
        if (rise_ok && (cyc - last_rise != exp_period)) period_bad++;
        last_rise = cyc; rise_ok = 1'b1;
      end
      if (o_rx_valid && rx_n < 64) begin rx_log[rx_n] = o_rx_data; rx_n++; end
      if (o_done) done_cnt++;
      if (!o_cs_n) cs_low++;
      if (o_cs_n && !prev_cs) cs_rise++;
      prev_sclk = o_sclk; prev_cs = o_cs_n;
    end
  end

  int n_checks = 0, n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_tx(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c, input int n);
    tx_tbl[0] = a; tx_tbl[1] = b; tx_tbl[2] = c; tx_tbl[3] = 8'h00;
    tx_n = n;
    tx_gen++;
    repeat (2) @(negedge clk);
  endtask

  task automatic start_txn(input logic [7:0] len, input logic [7:0] cdiv);
    @(negedge clk); i_start = 1'b1; i_len = len; i_cdiv = cdiv;
    @(negedge clk); i_start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int maxc);
    int base, n;
    base = done_cnt; n = 0;
    while (done_cnt == base && n < maxc) begin @(negedge clk); n++; end
    chk(tag, 32'(done_cnt != base), 32'd1);
    repeat (3) @(negedge clk);
  endtask

  int b_rx, b_done, b_cs, b_rise, b_pb, b_csr, b_sb, n;

  task automatic snap();
    b_rx = rx_n; b_done = done_cnt; b_cs = cs_low; b_rise = rise_cnt;
    b_pb = period_bad; b_csr = cs_rise; b_sb = stall_bad;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_cs_n", 32'(o_cs_n), 32'd1);
    chk("rst_start_n", 32'(o_div_start_n), 32'd1);
    chk("rst_busy", 32'(o_busy), 32'd0);
    chk("rst_done", 32'(o_done), 32'd0);
    chk("rst_tx_ready", 32'(o_tx_ready), 32'd0);
    chk("rst_rx_valid", 32'(o_rx_valid), 32'd0);
    chk("rst_mosi", 32'(o_mosi), 32'd0);
    chk("rst_rx_data", 32'(o_rx_data), 32'h00);
    chk("rst_div_config", 32'(o_div_config), 32'h000);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single byte, loopback, divisor 4
    loop = 1'b1; exp_period = 4;
    set_tx(8'hA5, 8'h00, 8'h00, 1);
    snap();
    start_txn(8'd1, 8'd4);
    chk("c1_busy", 32'(o_busy), 32'd1);
    chk("c1_cfg_load", 32'(o_div_config[0]), 32'd1);
    chk("c1_cfg_div", 32'(o_div_config[8:1]), 32'd4);
    chk("c1_cs_still_high", 32'(o_cs_n), 32'd1);
    @(negedge clk);
    chk("c2_cs_low", 32'(o_cs_n), 32'd0);
    chk("c2_cfg_strobe_off", 32'(o_div_config[0]), 32'd0);
    wait_done("single_done_seen", 300);
    chk("single_rises", 32'(rise_cnt - b_rise), 32'd8);
    chk("single_period", 32'(period_bad - b_pb), 32'd0);
    chk("single_rx_count", 32'(rx_n - b_rx), 32'd1);
    chk("single_rx_data", 32'(rx_log[b_rx]), 32'hA5);
    chk("single_done_once", 32'(done_cnt - b_done), 32'd1);
    chk("single_cs_low_cycles", 32'(cs_low - b_cs), 32'd39);
    chk("single_busy_low", 32'(o_busy), 32'd0);

    // Three bytes, slave returns its own pattern; a start mid-transfer is ignored
    loop = 1'b0; exp_period = 4;
    sl_tbl[0] = 8'h3C; sl_tbl[1] = 8'hC3; sl_tbl[2] = 8'h5A; sl_tbl[3] = 8'h00;
    set_tx(8'h01, 8'h80, 8'hFF, 3);
    snap();
    start_txn(8'd3, 8'd4);
    n = 0;
    while (rx_n == b_rx && n < 200) begin @(negedge clk); n++; end
    chk("three_first_byte_seen", 32'(rx_n != b_rx), 32'd1);
    i_start = 1'b1; i_len = 8'd5;
    @(negedge clk); i_start = 1'b0;
    wait_done("three_done_seen", 400);
    repeat (20) @(negedge clk);
    chk("three_rx_count", 32'(rx_n - b_rx), 32'd3);
    chk("three_rx0", 32'(rx_log[b_rx]), 32'h3C);
    chk("three_rx1", 32'(rx_log[b_rx+1]), 32'hC3);
    chk("three_rx2", 32'(rx_log[b_rx+2]), 32'h5A);
    chk("three_cs_single_rise", 32'(cs_rise - b_csr), 32'd1);
    chk("three_done_once", 32'(done_cnt - b_done), 32'd1);
    chk("three_rises", 32'(rise_cnt - b_rise), 32'd24);
    chk("three_idle_after", 32'(o_busy), 32'd0);

    // Divisor 0 sanitises to 2
    loop = 1'b1; exp_period = 2;
    set_tx(8'h96, 8'h00, 8'h00, 1);
    snap();
    start_txn(8'd1, 8'd0);
    chk("cdiv0_cfg_div", 32'(o_div_config[8:1]), 32'd2);
    wait_done("cdiv0_done_seen", 200);
    chk("cdiv0_rises", 32'(rise_cnt - b_rise), 32'd8);
    chk("cdiv0_period", 32'(period_bad - b_pb), 32'd0);
    chk("cdiv0_rx", 32'(rx_log[b_rx]), 32'h96);

    // Divisor 7 sanitises to 6
    exp_period = 6;
    set_tx(8'h5C, 8'h00, 8'h00, 1);
    snap();
    start_txn(8'd1, 8'd7);
    chk("cdiv7_cfg_div", 32'(o_div_config[8:1]), 32'd6);
    wait_done("cdiv7_done_seen", 300);
    chk("cdiv7_rises", 32'(rise_cnt - b_rise), 32'd8);
    chk("cdiv7_period", 32'(period_bad - b_pb), 32'd0);
    chk("cdiv7_rx", 32'(rx_log[b_rx]), 32'h5C);

    // Underflow: second byte withheld for 20 cycles in LOAD
    exp_period = 4; stall_idx = 1; stall_init = 20;
    set_tx(8'h12, 8'h34, 8'h00, 2);
    snap();
    start_txn(8'd2, 8'd4);
    wait_done("stall_done_seen", 400);
    chk("stall_fully_applied", 32'(stall_left), 32'd0);
    chk("stall_sclk_cs_idle", 32'(stall_bad - b_sb), 32'd0);
    chk("stall_rx_count", 32'(rx_n - b_rx), 32'd2);
    chk("stall_rx0", 32'(rx_log[b_rx]), 32'h12);
    chk("stall_rx1", 32'(rx_log[b_rx+1]), 32'h34);
    chk("stall_cs_single_rise", 32'(cs_rise - b_csr), 32'd1);
    stall_idx = 99; stall_init = 0;

    // Zero-length transaction
    snap();
    start_txn(8'd0, 8'd4);
    chk("len0_done_next_cycle", 32'(o_done), 32'd1);
    chk("len0_busy_low", 32'(o_busy), 32'd0);
    repeat (5) @(negedge clk);
    chk("len0_cs_never_low", 32'(cs_low - b_cs), 32'd0);
    chk("len0_done_once", 32'(done_cnt - b_done), 32'd1);

    // Reset in the middle of a burst
    set_tx(8'hE7, 8'h00, 8'h00, 1);
    snap();
    start_txn(8'd1, 8'd4);
    n = 0;
    while (rise_cnt - b_rise < 3 && n < 200) begin @(negedge clk); n++; end
    chk("rst_mid_burst_reached", 32'(rise_cnt - b_rise >= 3), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_mid_cs_high", 32'(o_cs_n), 32'd1);
    chk("rst_mid_busy_low", 32'(o_busy), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    chk("rst_mid_no_rx_valid", 32'(rx_n - b_rx), 32'd0);
    chk("rst_mid_no_done", 32'(done_cnt - b_done), 32'd0);
    chk("rst_mid_idle_cs", 32'(o_cs_n), 32'd1);

    // Normal operation after the mid-burst reset
    set_tx(8'h3B, 8'h00, 8'h00, 1);
    snap();
    start_txn(8'd1, 8'd4);
    wait_done("post_rst_done_seen", 300);
    chk("post_rst_rx", 32'(rx_log[b_rx]), 32'h3B);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/spi_master_sequencer.md
# spi_master_sequencer

Transaction-level SPI mode-0 master controller that owns and sequences one `clock_divider` instance. It programs the divisor, drives chip select with programmable setup and hold, and streams an N-byte transaction. Each byte is one 8-slow-clock burst of the divider. It sits between a host byte-stream interface and the SPI pins, turning the divider's edge strobes into MOSI shifting and MISO sampling.

## Interface
- P_CS_SETUP, 2: i_clk cycles from o_cs_n falling to the first byte start (1..255).
- P_CS_HOLD, 2: i_clk cycles from the last byte's completion to o_cs_n rising (1..255).
- P_GAP, 0: idle i_clk cycles between consecutive bytes (0..255).

Ports (reset i_rst_n, synchronous, active-low; clock i_clk):
- i_clk  in  1  system clock
- i_rst_n  in  1  synchronous active-low reset
- i_start  in  1  single-cycle transaction request; sampled only in IDLE
- i_len  in  8  byte count, latched with i_start
- i_cdiv  in  8  SCLK divisor, latched with i_start
- o_busy  out  1  high from the cycle after an accepted i_start until o_done
- o_done  out  1  one-cycle pulse at transaction end
- i_tx_data  in  8  next MOSI byte
- i_tx_valid  in  1  tx byte available
- o_tx_ready  out  1  tx handshake; a transfer occurs when valid and ready are both high
- o_rx_data  out  8  last received byte; held until the next update
- o_rx_valid  out  1  one-cycle pulse per received byte; no backpressure
- o_sclk  out  1  SPI clock, equal to i_div_clk
- o_mosi  out  1  SPI data out
- i_miso  in  1  SPI data in
- o_cs_n  out  1  chip select, active low
- o_div_config  out  9  divider config: [8:1] divisor, [0] load strobe
- o_div_start_n  out  1  divider start, active low
- i_div_ready, i_div_clk, i_div_rising, i_div_falling  in  1  divider status; the rising and falling strobes announce the SCLK edge at the next i_clk edge

## Operation
- States: IDLE, CONFIG, CS_SETUP, LOAD, START, WAIT_BUSY, WAIT_DONE, GAP, CS_HOLD, DONE.
- IDLE
  - When i_start=1 and i_len=0: go to DONE; o_cs_n never asserts.
  - When i_start=1 otherwise: latch i_len and the sanitised divisor, then go to CONFIG.
  - Divisor sanitising: clear the LSB; if the result is < 2, use 2.
- CONFIG: wait for i_div_ready=1, then drive o_div_config={divisor,1} for exactly one cycle, then go to CS_SETUP.
- CS_SETUP: o_cs_n=0; count P_CS_SETUP cycles, then go to LOAD.
- LOAD: o_tx_ready=1.
  - On handshake: load the shift register with i_tx_data, o_mosi=bit7, go to START.
  - With no valid byte: stall indefinitely with o_cs_n=0 and SCLK idle low.
- START: o_div_start_n=0 for one cycle, then go to WAIT_BUSY.
- WAIT_BUSY: wait for i_div_ready=0, then go to WAIT_DONE.
- WAIT_DONE
  - On the edge where i_div_rising=1: shift i_miso into rx bit 0 (MSB first).
  - On the edge where i_div_falling=1: shift tx left and update o_mosi. The falling strobe after the 8th rising edge is ignored via a 3-bit bit counter.
  - When i_div_ready=1: o_rx_data=rx byte, o_rx_valid pulses, decrement the byte counter.
  - Then go to CS_HOLD if the counter reaches 0, otherwise to GAP.
- GAP: P_GAP cycles (a zero-cycle pass-through when P_GAP=0), then go to LOAD.
- CS_HOLD: count P_CS_HOLD cycles with o_cs_n=0, then o_cs_n=1 and go to DONE.
- DONE: o_done=1 for one cycle, o_busy falls in the same cycle, then go to IDLE.
- i_start is ignored outside IDLE.
- A reset at any point returns to IDLE.
  - o_cs_n is high from the first cycle after the reset edge.
  - All strobes are deasserted.
  - No partial o_rx_valid is issued.

## Timing
- Reset values:
  - o_cs_n=1, o_div_start_n=1.
  - o_busy=0, o_done=0, o_tx_ready=0, o_rx_valid=0.
  - o_mosi=0, o_rx_data=0x00, o_div_config=0x000.
- Accepted i_start at cycle 0:
  - o_busy=1 at cycle 1.
  - If the divider is already ready, o_div_config[0]=1 at cycle 1.
  - o_cs_n=0 at cycle 2.
- o_mosi holds the data MSB at least one i_clk before the first SCLK rising edge.
- o_mosi changes only coincident with SCLK falling edges.
- i_miso is sampled on the i_clk edge where SCLK rises.
- o_rx_valid for byte k precedes the o_div_start_n pulse for byte k+1.
- All outputs are registered; o_sclk is a direct pass-through of i_div_clk.

## Test plan
- Reset: hold i_rst_n=0 for 3 cycles mid-WAIT_DONE -> o_cs_n=1 one cycle after the reset edge; no o_rx_valid; IDLE afterwards.
- Single byte: i_len=1, i_cdiv=4, tx=0xA5, slave loopback MISO=MOSI -> 8 SCLK pulses with period 4 i_clk; o_rx_data=0xA5; o_done once; o_cs_n low for the burst plus setup and hold.
- Three bytes: i_len=3, tx 0x01/0x80/0xFF, slave returns 0x3C/0xC3/0x5A -> three o_rx_valid pulses in that order; o_cs_n stays low throughout.
- Divisor edge cases: i_cdiv=0 and i_cdiv=7 -> o_div_config[8:1]=2 and 6 respectively; o_sclk periods of 2 and 6 cycles.
- Underflow: i_len=2 with i_tx_valid deasserted for 20 cycles between bytes -> o_sclk stays 0 and o_cs_n stays 0 during the stall; the transaction completes normally.
- i_len=0 and a start while busy: i_len=0 -> o_done one cycle later with o_cs_n never low; an i_start during a transfer -> ignored, and the byte count is unchanged.
